id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage directly upstream of the ALU. Decodes RV32 instr into
//  alu_control, selects and registers ALU operands plus writeback/memory
//  control, and feeds them to EX through a valid/ready handshake.
//  A 2-entry skid buffer gives full throughput under back-pressure.
//  Flush support handles branch redirects.
// PARAMETERS
//  XLEN   32  datapath width (operands, pc, forwarding data)
//  CNT_W  16  width of stall_cnt performance counter
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  flush        in   1     sync flush: drops all buffered and incoming beats
//  in_valid     in   1     upstream beat valid
//  in_ready     out  1     stage can accept (registered; = !skid_valid)
//  instr        in   32    instruction word
//  rs1_data     in   XLEN  register-file read data rs1
//  rs2_data     in   XLEN  register-file read data rs2
//  out_valid    out  1     EX beat valid
//  out_ready    in   1     EX consumes beat
//  alu_in1      out  XLEN  ALU operand 1
//  alu_in2      out  XLEN  ALU operand 2 (rs2_data or immediate)
//  alu_control  out  4     ALU op code
//  rd           out  5     destination register
//  reg_write    out  1     writeback enable
//  mem_read     out  1     load
//  mem_write    out  1     store; store data on st_data
//  st_data      out  XLEN  rs2 value for stores
//  branch       out  1     conditional branch (EX checks zero_flag)
//  illegal      out  1     unsupported encoding; all enables forced 0
//  stall_cnt    out  CNT_W cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, every data/control output 0, stall_cnt=0.
//  Decode (ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0100, SLT 1000,
//  SLL 0011, SRL 0101, MUL 0110, XOR 0111):
//   - opcode 0110011, f7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 100 XOR,
//     101 SRL, 110 OR, 111 AND. f7=0100000,f3=000 SUB.
//     f7=0000001,f3=000 MUL. in2=rs2_data, reg_write=1.
//   - opcode 0010011: same f3 map, in2 = sext(instr[31:20]). SLLI/SRLI
//     need f7=0 and use in2 = zext(instr[24:20]). reg_write=1.
//   - 0000011 load: ADD, in2 = I-imm, mem_read=1, reg_write=1.
//   - 0100011 store: ADD, in2 = sext({instr[31:25],instr[11:7]}), mem_write=1.
//   - 1100011: SUB, in2=rs2_data, branch=1.
//   - anything else (incl. SRA, SLTU, other f3/f7): illegal=1, alu_control=0000.
//  Handshake: accept = in_valid & in_ready. Latency 1 cycle; 1 beat/cycle.
//   - main empty or out_ready: accepted beat loads main.
//   - main valid & !out_ready & accept: beat loads skid; in_ready=0 next cycle.
//   - out_ready & skid valid: skid moves to main; in_ready=1 next cycle.
//   - outputs stable while out_valid & !out_ready; no beat dropped or duplicated.
//  Flush: highest priority; main and skid invalid next edge; beat accepted in
//   the flush cycle is discarded; in_ready=1 the following cycle.
//  stall_cnt: +1 per stall cycle, holds at all-ones, cleared only by reset.
//  Reset mid-operation: immediate return to reset values, buffered beats lost.
// CONFIGURATION
//  ID_EX_FWD_EN defined: adds inputs fwd_valid(1), fwd_rd(5), fwd_data(XLEN).
//   At capture, if fwd_valid & fwd_rd!=0 & fwd_rd==rs1 (instr[19:15]), then
//   rs1_data is replaced by fwd_data. The same rule applies to rs2
//   (instr[24:20]) in alu_in2/st_data where rs2 is used. Entries already
//   buffered are not re-forwarded.
//  Undefined: ports absent, rs1_data/rs2_data used as given.
// TESTING
//  add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle
//   out_valid=1, in1=5, in2=7, ctrl=0010, rd=3, reg_write=1
//  addi x1,x0,-1 (0xFFF00093) -> in2=0xFFFFFFFF, ctrl=0010
//  sw (0x0020A423), rs2=0xAB -> in2=8, mem_write=1, st_data=0xAB, reg_write=0
//  3 back-to-back beats, out_ready low 4 cycles -> in_ready low after 2nd
//   beat; all 3 delivered in order; stall_cnt=4
//  flush with main+skid full and in_valid=1 -> out_valid=0 next cycle,
//   in_ready=1, no stale beat emitted
//  sra (0x4020D1B3) -> illegal=1, ctrl=0000, reg_write=0
//  ID_EX_FWD_EN: fwd_rd=1, fwd_data=0x55, add x3,x1,x2 -> in1=0x55;
//   fwd_rd=0 -> no forward

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX stage: RV32 decode into ALU operands and control, registered behind a 2-entry skid buffer.
// Define ID_EX_FWD_EN to add capture-time operand forwarding (fwd_valid/fwd_rd/fwd_data).
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
`ifdef ID_EX_FWD_EN
    input  logic             fwd_valid,
    input  logic [4:0]       fwd_rd,
    input  logic [XLEN-1:0]  fwd_data,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_in1,
    output logic [XLEN-1:0]  alu_in2,
    output logic [3:0]       alu_control,
    output logic [4:0]       rd,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic [XLEN-1:0]  st_data,
    output logic             branch,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_MUL = 4'b0110,
        ALU_XOR = 4'b0111,
        ALU_SLT = 4'b1000
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] st;
        alu_op_e         ctrl;
        logic [4:0]      rd;
        logic            rw;
        logic            mr;
        logic            mw;
        logic            br;
        logic            ill;
    } beat_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1_v, rs2_v, imm_i, imm_s, shamt;
    logic            f3_ok, legal, accept;
    alu_op_e         f3_op;
    beat_t           dec, main_q, main_d, skid_q, skid_d;
    logic            main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

`ifdef ID_EX_FWD_EN
    // Forwarding applies only at capture; buffered entries keep the values they were taken with.
    assign rs1_v = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == instr[19:15]) ? fwd_data : rs1_data;
    assign rs2_v = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == instr[24:20]) ? fwd_data : rs2_data;
`else
    logic unused_rs1_idx;
    assign unused_rs1_idx = ^instr[19:15];
    assign rs1_v = rs1_data;
    assign rs2_v = rs2_data;
`endif

    always_comb begin
        f3_ok = 1'b1;
        f3_op = ALU_AND;
        case (funct3)
            3'b000:  f3_op = ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            3'b111:  f3_op = ALU_AND;
            default: f3_ok = 1'b0;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path leaves a value held (no latch).
    always_comb begin
        dec     = '0;
        dec.in1 = rs1_v;
        dec.in2 = rs2_v;
        dec.rd  = instr[11:7];
        legal   = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000 && f3_ok) begin
                    legal    = 1'b1;
                    dec.ctrl = f3_op;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal    = 1'b1;
                    dec.ctrl = ALU_SUB;
                end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
                    legal    = 1'b1;
                    dec.ctrl = ALU_MUL;
                end
                dec.rw = 1'b1;
            end
            OP_I: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    legal   = (funct7 == 7'b0000000);
                    dec.in2 = shamt;
                end else begin
                    legal   = f3_ok;
                    dec.in2 = imm_i;
                end
                dec.ctrl = f3_op;
                dec.rw   = 1'b1;
            end
            OP_LOAD: begin
                legal    = 1'b1;
                dec.ctrl = ALU_ADD;
                dec.in2  = imm_i;
                dec.mr   = 1'b1;
                dec.rw   = 1'b1;
            end
            OP_STORE: begin
                legal    = 1'b1;
                dec.ctrl = ALU_ADD;
                dec.in2  = imm_s;
                dec.mw   = 1'b1;
                dec.st   = rs2_v;
            end
            OP_BRANCH: begin
                legal    = 1'b1;
                dec.ctrl = ALU_SUB;
                dec.br   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Unsupported encodings travel down the pipe with every enable cleared.
        if (!legal) begin
            dec.ctrl = ALU_AND;
            dec.in2  = rs2_v;
            dec.st   = '0;
            dec.rw   = 1'b0;
            dec.mr   = 1'b0;
            dec.mw   = 1'b0;
            dec.br   = 1'b0;
            dec.ill  = 1'b1;
        end
    end

    assign in_ready = ~skid_v_q;
    assign accept   = in_valid & in_ready;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        cnt_d    = cnt_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || out_ready) begin
            // The skid entry is older than anything arriving now, so it drains first.
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = accept;
                if (accept) main_d = dec;
            end
        end else if (accept) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
        if (main_v_q && !out_ready && cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
    end

    // NOTE: payload registers are reset too, because the outputs must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            main_q   <= main_d;
            main_v_q <= main_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid   = main_v_q;
    assign alu_in1     = main_q.in1;
    assign alu_in2     = main_q.in2;
    assign alu_control = main_q.ctrl;
    assign rd          = main_q.rd;
    assign reg_write   = main_q.rw;
    assign mem_read    = main_q.mr;
    assign mem_write   = main_q.mw;
    assign st_data     = main_q.st;
    assign branch      = main_q.br;
    assign illegal     = main_q.ill;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected beats are queued when driven and compared on transfer.
// Also covers back-pressure, flush, stall counting, async reset and (when defined) ID_EX_FWD_EN.
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] st;
        logic [3:0]      ctrl;
        logic [4:0]      rd;
        logic            rw;
        logic            mr;
        logic            mw;
        logic            br;
        logic            ill;
    } exp_t;

    logic             clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  rs1_data, rs2_data, alu_in1, alu_in2, st_data;
    logic [3:0]       alu_control;
    logic [4:0]       rd;
    logic             reg_write, mem_read, mem_write, branch, illegal;
    logic [CNT_W-1:0] stall_cnt;
`ifdef ID_EX_FWD_EN
    logic             fwd_valid;
    logic [4:0]       fwd_rd;
    logic [XLEN-1:0]  fwd_data;
`endif

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef ID_EX_FWD_EN
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_control(alu_control), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .st_data(st_data), .branch(branch), .illegal(illegal),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] in1, input logic [31:0] in2, input logic [31:0] st,
                                input logic [3:0] ctrl, input logic [4:0] rdv, input logic rw,
                                input logic mr, input logic mw, input logic br, input logic ill);
        mk = {in1, in2, st, ctrl, rdv, rw, mr, mw, br, ill};
    endfunction

    // Drive one beat, wait (bounded) for in_ready, optionally queue its expectation, then take the edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input bit push);
        int n = 0;
        instr = ins; rs1_data = a; rs2_data = b; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("send_ready_timeout", in_ready, 1'b1);
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t o, e;
        if (rst_n && out_valid && out_ready) begin
            o = {alu_in1, alu_in2, st_data, alu_control, rd, reg_write, mem_read, mem_write, branch, illegal};
            if (exp_q.size() == 0) check("unexpected_beat", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                check("beat", o, e);
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs1_data = '0; rs2_data = '0;
`ifdef ID_EX_FWD_EN
        fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_alu_in1", alu_in1, 0);
        check("rst_ctrl_rw", {alu_control, reg_write, illegal}, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Decode stream at full throughput
        send(32'h002081B3, 5, 7, mk(5, 7, 0, 4'b0010, 3, 1, 0, 0, 0, 0), 1);
        check("add_out_valid", out_valid, 1'b1);
        send(32'hFFF00093, 32'h10, 32'h99, mk(32'h10, 32'hFFFFFFFF, 0, 4'b0010, 1, 1, 0, 0, 0, 0), 1);
        send(32'h0020A423, 32'h100, 32'hAB, mk(32'h100, 8, 32'hAB, 4'b0010, 8, 0, 0, 1, 0, 0), 1);
        send(32'h4020D1B3, 1, 2, mk(1, 2, 0, 4'b0000, 3, 0, 0, 0, 0, 1), 1);
        send(32'h407302B3, 20, 7, mk(20, 7, 0, 4'b0100, 5, 1, 0, 0, 0, 0), 1);
        send(32'h02C58533, 3, 4, mk(3, 4, 0, 4'b0110, 10, 1, 0, 0, 0, 0), 1);
        send(32'h0020A233, 11, 12, mk(11, 12, 0, 4'b1000, 4, 1, 0, 0, 0, 0), 1);
        send(32'h0020C233, 13, 14, mk(13, 14, 0, 4'b0111, 4, 1, 0, 0, 0, 0), 1);
        send(32'h0020E233, 15, 16, mk(15, 16, 0, 4'b0001, 4, 1, 0, 0, 0, 0), 1);
        send(32'h0020F233, 17, 18, mk(17, 18, 0, 4'b0000, 4, 1, 0, 0, 0, 0), 1);
        send(32'h00209233, 19, 20, mk(19, 20, 0, 4'b0011, 4, 1, 0, 0, 0, 0), 1);
        send(32'h0020D233, 21, 22, mk(21, 22, 0, 4'b0101, 4, 1, 0, 0, 0, 0), 1);
        send(32'h0020B233, 23, 24, mk(23, 24, 0, 4'b0000, 4, 0, 0, 0, 0, 1), 1);
        send(32'h00331293, 32'h40, 32'h77, mk(32'h40, 3, 0, 4'b0011, 5, 1, 0, 0, 0, 0), 1);
        send(32'h01F35293, 32'h40, 32'h77, mk(32'h40, 31, 0, 4'b0101, 5, 1, 0, 0, 0, 0), 1);
        send(32'h40335293, 32'h40, 32'h77, mk(32'h40, 32'h77, 0, 4'b0000, 5, 0, 0, 0, 0, 1), 1);
        send(32'h80034293, 32'h41, 32'h78, mk(32'h41, 32'hFFFFF800, 0, 4'b0111, 5, 1, 0, 0, 0, 0), 1);
        send(32'h00C32283, 32'h500, 0, mk(32'h500, 12, 0, 4'b0010, 5, 1, 1, 0, 0, 0), 1);
        send(32'hFE20AE23, 32'h200, 32'hDEAD, mk(32'h200, 32'hFFFFFFFC, 32'hDEAD, 4'b0010, 28, 0, 0, 1, 0, 0), 1);
        send(32'h00208463, 9, 9, mk(9, 9, 0, 4'b0100, 8, 0, 0, 0, 1, 0), 1);
        send(32'h123450B7, 25, 26, mk(25, 26, 0, 4'b0000, 1, 0, 0, 0, 0, 1), 1);
        drain();
        check("no_stall_yet", stall_cnt, 0);

        // Back-pressure: three back-to-back beats, out_ready low for four edges
        out_ready = 1'b0;
        send(32'h002081B3, 1, 2, mk(1, 2, 0, 4'b0010, 3, 1, 0, 0, 0, 0), 1);
        send(32'h407302B3, 30, 7, mk(30, 7, 0, 4'b0100, 5, 1, 0, 0, 0, 0), 1);
        check("bp_in_ready_low", in_ready, 1'b0);
        instr = 32'h00C32283; rs1_data = 32'h1000; rs2_data = 0; in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("bp_hold_in1", alu_in1, 1);
        check("bp_hold_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        check("bp_stall_cnt4", stall_cnt, 4);
        out_ready = 1'b1;
        exp_q.push_back(mk(32'h1000, 12, 0, 4'b0010, 5, 1, 1, 0, 0, 0));
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("bp_ready_back", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        check("bp_stall_final", stall_cnt, 4);

        // Flush with main and skid occupied and a beat offered
        out_ready = 1'b0;
        send(32'h002081B3, 61, 62, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        send(32'h002081B3, 63, 64, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        check("fl_in_ready_low", in_ready, 1'b0);
        instr = 32'h002081B3; rs1_data = 65; rs2_data = 66; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_in_ready", in_ready, 1'b1);
        check("fl_stall_cnt", stall_cnt, 6);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("fl_no_stale", out_valid, 1'b0);

        // Beat accepted in the flush cycle is discarded
        instr = 32'h002081B3; rs1_data = 67; rs2_data = 68; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_accept_dropped", out_valid, 1'b0);
        send(32'h0020E233, 70, 71, mk(70, 71, 0, 4'b0001, 4, 1, 0, 0, 0, 0), 1);
        drain();

`ifdef ID_EX_FWD_EN
        fwd_valid = 1'b1; fwd_rd = 5'd1; fwd_data = 32'h55;
        send(32'h002081B3, 5, 7, mk(32'h55, 7, 0, 4'b0010, 3, 1, 0, 0, 0, 0), 1);
        fwd_rd = 5'd0;
        send(32'hFFF00093, 0, 32'h99, mk(0, 32'hFFFFFFFF, 0, 4'b0010, 1, 1, 0, 0, 0, 0), 1);
        fwd_rd = 5'd2; fwd_data = 32'h66;
        send(32'h0020A423, 32'h100, 32'hAB, mk(32'h100, 8, 32'h66, 4'b0010, 8, 0, 0, 1, 0, 0), 1);
        fwd_valid = 1'b0;
        drain();
`endif

        // Asynchronous reset while both entries are occupied
        out_ready = 1'b0;
        send(32'h002081B3, 81, 82, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        send(32'h002081B3, 83, 84, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_stall_cnt", stall_cnt, 0);
        check("mid_rst_alu_in1", alu_in1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
